// File: rtl/linear_interpolator_if.sv
// Sample-in / ramp-out bundle for linear_interpolator.
// The upstream setpoint source and the ramp generator share this interface.
interface linear_interpolator_if #(
  parameter int data_bits = 16
);
  logic                 step_en;
  logic [data_bits-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [data_bits-1:0] out_data;
  logic                 out_strobe;
  logic                 busy;

  modport master (
    output step_en, in_data, in_valid,
    input  in_ready, out_data, out_strobe, busy
  );

  modport slave (
    input  step_en, in_data, in_valid,
    output in_ready, out_data, out_strobe, busy
  );
endinterface

// File: rtl/linear_interpolator.sv
// Linear ramp generator: moves out_data from its current value to each new sample
// in exactly 2^log2_steps step ticks, with one sample of look-ahead buffering.
module linear_interpolator #(
  parameter int data_bits  = 16,
  parameter int log2_steps = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  linear_interpolator_if.slave  bus
);

  localparam int acc_bits = data_bits + log2_steps + 1;
  localparam logic [log2_steps-1:0] cnt_one = log2_steps'(1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t                 state_q, state_d;
  logic [acc_bits-1:0]    acc_q, acc_d;
  logic [data_bits:0]     delta_q, delta_d;
  logic [log2_steps-1:0]  cnt_q, cnt_d;
  logic [data_bits-1:0]   pend_q, pend_d;
  logic                   pend_v_q, pend_v_d;
  logic [data_bits-1:0]   target_q, target_d;
  logic [data_bits-1:0]   out_data_q, out_data_d;
  logic                   out_strobe_q, out_strobe_d;
  logic                   busy_q, busy_d;

  logic                   accept;
  logic                   final_step;
  logic [acc_bits-1:0]    acc_sum;
  logic                   do_load;
  logic [data_bits-1:0]   load_s;
  logic [data_bits-1:0]   load_t;

  assign bus.in_ready   = rst & ~pend_v_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.busy       = busy_q;

  assign accept     = bus.in_valid & bus.in_ready;
  assign final_step = (state_q == RAMP) && bus.step_en && (cnt_q == '1);

  // Accumulator carries a guard bit above the sample range, so T - S never overflows.
  assign acc_sum = acc_q + {{log2_steps{delta_q[data_bits]}}, delta_q};

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    delta_d      = delta_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    target_d     = target_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    do_load      = 1'b0;
    load_s       = target_q;
    load_t       = bus.in_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          do_load = 1'b1;
          load_s  = out_data_q;
        end
      end
      RAMP: begin
        if (bus.step_en) begin
          acc_d        = acc_sum;
          out_data_d   = acc_sum[log2_steps +: data_bits];
          out_strobe_d = 1'b1;
          cnt_d        = cnt_q + cnt_one;
          if (final_step) begin
            if (pend_v_q) begin
              do_load  = 1'b1;
              load_t   = pend_q;
              pend_v_d = 1'b0;
            end else if (accept) begin
              do_load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        // Samples arriving mid-ramp wait their turn; the final step consumes them directly.
        if (accept && !final_step) begin
          pend_d   = bus.in_data;
          pend_v_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      delta_d  = {load_t[data_bits-1], load_t} - {load_s[data_bits-1], load_s};
      acc_d    = {load_s[data_bits-1], load_s, {log2_steps{1'b0}}};
      cnt_d    = '0;
      target_d = load_t;
      state_d  = RAMP;
    end

    busy_d = (state_d == RAMP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      delta_q      <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      target_q     <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      delta_q      <= delta_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      target_q     <= target_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_linear_interpolator.sv
// Directed bench for linear_interpolator: short-ramp instance (log2_steps=2)
// and full-scale instance (log2_steps=8) driven by one linear stimulus sequence.
module tb_linear_interpolator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  linear_interpolator_if #(.data_bits(16)) a_if ();
  linear_interpolator_if #(.data_bits(16)) b_if ();

  linear_interpolator #(.data_bits(16), .log2_steps(2)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  linear_interpolator #(.data_bits(16), .log2_steps(8)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock on instance a, then check the new output value and its strobe.
  task automatic step_a(input string tag, input int exp_out, input logic exp_stb);
    tick();
    chk(tag, $signed(a_if.out_data), exp_out);
    chk({tag, "_stb"}, a_if.out_strobe, exp_stb);
  endtask

  task automatic accept_a(input int value);
    a_if.in_data  = 16'(value);
    a_if.in_valid = 1'b1;
    tick();
    a_if.in_valid = 1'b0;
  endtask

  initial begin
    int prev;
    int v;
    int bad_mono;
    int k_steps;

    a_if.step_en = 1'b1;
    a_if.in_data = '0;
    a_if.in_valid = 1'b0;
    b_if.step_en = 1'b1;
    b_if.in_data = '0;
    b_if.in_valid = 1'b0;

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_out", $signed(a_if.out_data), 0);
    chk("rst_stb", a_if.out_strobe, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_rdy", a_if.in_ready, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rel_rdy", a_if.in_ready, 1);

    // 0 -> 100
    accept_a(100);
    chk("acc_busy", a_if.busy, 1);
    chk("acc_out", $signed(a_if.out_data), 0);
    step_a("r100_1", 25, 1);
    step_a("r100_2", 50, 1);
    step_a("r100_3", 75, 1);
    step_a("r100_4", 100, 1);
    chk("r100_busy", a_if.busy, 0);
    step_a("r100_hold", 100, 0);

    // 100 -> -100
    accept_a(-100);
    step_a("rn100_1", 50, 1);
    step_a("rn100_2", 0, 1);
    step_a("rn100_3", -50, 1);
    step_a("rn100_4", -100, 1);

    // -100 -> 0
    accept_a(0);
    step_a("r0a_1", -75, 1);
    step_a("r0a_2", -50, 1);
    step_a("r0a_3", -25, 1);
    step_a("r0a_4", 0, 1);

    // 0 -> 3
    accept_a(3);
    step_a("r3_1", 0, 1);
    step_a("r3_2", 1, 1);
    step_a("r3_3", 2, 1);
    step_a("r3_4", 3, 1);

    // 3 -> 0
    accept_a(0);
    step_a("r0b_1", 2, 1);
    step_a("r0b_2", 1, 1);
    step_a("r0b_3", 0, 1);
    step_a("r0b_4", 0, 1);

    // 0 -> -3, floor rounding
    accept_a(-3);
    step_a("rn3_1", -1, 1);
    step_a("rn3_2", -2, 1);
    step_a("rn3_3", -3, 1);
    step_a("rn3_4", -3, 1);

    // -3 -> 0
    accept_a(0);
    step_a("r0c_1", -3, 1);
    step_a("r0c_2", -2, 1);
    step_a("r0c_3", -1, 1);
    step_a("r0c_4", 0, 1);

    // Back-to-back ramps: 40 accepted, 80 buffered, third sample refused
    accept_a(40);
    a_if.in_data = 16'd80;
    a_if.in_valid = 1'b1;
    step_a("bb_1", 10, 1);
    chk("bb_rdy1", a_if.in_ready, 0);
    a_if.in_data = 16'd999;
    step_a("bb_2", 20, 1);
    chk("bb_rdy2", a_if.in_ready, 0);
    step_a("bb_3", 30, 1);
    a_if.in_valid = 1'b0;
    step_a("bb_4", 40, 1);
    chk("bb_rdy3", a_if.in_ready, 1);
    chk("bb_busy4", a_if.busy, 1);
    step_a("bb_5", 50, 1);
    step_a("bb_6", 60, 1);
    step_a("bb_7", 70, 1);
    step_a("bb_8", 80, 1);
    chk("bb_busy8", a_if.busy, 0);
    step_a("bb_hold", 80, 0);

    // Sparse step ticks: 80 -> 100, step_en on every third cycle
    a_if.step_en = 1'b0;
    accept_a(100);
    k_steps = 0;
    for (int c = 0; c < 12; c++) begin
      a_if.step_en = (c % 3 == 2);
      if (a_if.step_en) k_steps++;
      step_a("sp", 80 + 5 * k_steps, a_if.step_en);
    end
    chk("sp_busy", a_if.busy, 0);
    a_if.step_en = 1'b1;

    // Full-scale ramps on the log2_steps=8 instance
    b_if.in_data = 16'sd32767;
    b_if.in_valid = 1'b1;
    tick();
    b_if.in_valid = 1'b0;
    tick();
    chk("fs_up_1", $signed(b_if.out_data), 127);
    for (int k = 2; k <= 256; k++) tick();
    chk("fs_up_end", $signed(b_if.out_data), 32767);
    chk("fs_up_busy", b_if.busy, 0);

    b_if.in_data = 16'h8000;
    b_if.in_valid = 1'b1;
    tick();
    b_if.in_valid = 1'b0;
    prev = 32767;
    bad_mono = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      v = $signed(b_if.out_data);
      if (v > prev) bad_mono++;
      prev = v;
      if (k == 1) chk("fs_dn_1", v, 32511);
      if (k == 255) begin
        chk("fs_dn_255", v, -32513);
        chk("fs_dn_busy255", b_if.busy, 1);
      end
    end
    chk("fs_dn_mono", bad_mono, 0);
    chk("fs_dn_end", $signed(b_if.out_data), -32768);
    chk("fs_dn_busy", b_if.busy, 0);

    // Reset mid-ramp with a sample pending
    accept_a(0);
    a_if.in_data = 16'd50;
    a_if.in_valid = 1'b1;
    step_a("mr_1", 75, 1);
    a_if.in_valid = 1'b0;
    chk("mr_rdy", a_if.in_ready, 0);
    a_if.step_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mr_out", $signed(a_if.out_data), 0);
    chk("mr_busy", a_if.busy, 0);
    chk("mr_rdy0", a_if.in_ready, 0);
    chk("mr_stb", a_if.out_strobe, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("mr_rdy1", a_if.in_ready, 1);
    a_if.step_en = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("mr_after_out", $signed(a_if.out_data), 0);
    chk("mr_after_busy", a_if.busy, 0);
    chk("mr_after_stb", a_if.out_strobe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/linear_interpolator.md
Name: linear_interpolator

Overview:
- Rate-expanding counterpart to the team's averaging/decimating filter.
- Accepts slow, sparse signed samples through a valid/ready handshake and produces a full-rate output that ramps linearly from the current output value to each new sample in exactly 2^log2_steps step ticks.
- Sits between slow control or setpoint logic and the DAC path, so that setpoint jumps reach the actuator as bounded-slope ramps instead of steps.
- Holds one pending sample so that consecutive ramps run back to back with no gap.

Parameters:
- data_bits, 16, width of input and output samples (two's complement).
- log2_steps, 8, log2 of the number of step ticks per ramp; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- step_en  input  1  step tick; a ramp advances only on cycles where this is 1.
- in_data  input  data_bits  new target sample, signed.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a sample; equals rst AND NOT pend_v (combinational).
- out_data  output  data_bits  interpolated output, registered, signed.
- out_strobe  output  1  registered; 1 for one cycle after each ramp step that updated out_data.
- busy  output  1  registered; 1 while in RAMP.

Behaviour:
- Reset (rst=0, async):
  - out_data=0, out_strobe=0, busy=0, state=IDLE.
  - acc=0, delta=0, cnt=0, pend_v=0, pend=0, target=0.
  - in_ready=0 while rst=0.
- Internal widths:
  - delta is data_bits+1 signed.
  - acc is data_bits+log2_steps+1 signed.
  - cnt is log2_steps bits.
  - All arithmetic sign-extended; no overflow is possible for any input pair, including full-scale to full-scale.
- Ramp load from start value S to new target T:
  - delta <= T - S.
  - acc <= S sign-extended, shifted left by log2_steps.
  - cnt <= 0, target <= T, state <= RAMP.
- IDLE:
  - Accept (in_valid && in_ready) performs a ramp load with S=out_data and T=in_data; pend is not used.
  - out_data holds its value.
- RAMP step (cycle with step_en=1):
  - acc <= acc + delta.
  - out_data <= (acc + delta) >> log2_steps (arithmetic shift, floor rounding).
  - out_strobe <= 1, cnt <= cnt + 1.
  - After step k (k = 1..2^log2_steps), out_data = S + floor(k*delta / 2^log2_steps).
  - At k = 2^log2_steps, out_data equals T exactly.
- RAMP cycle with step_en=0: all state holds; out_strobe <= 0.
- Accept while in RAMP: in_data is stored in pend and pend_v <= 1.
  - in_ready therefore drops the cycle after the accept.
  - Only one sample is buffered.
- Final step (cnt = 2^log2_steps - 1 and step_en=1):
  - If pend_v: ramp load with S=target and T=pend, pend_v <= 0, stay in RAMP. The first step of the new ramp occurs on the next step_en.
  - Else, if an accept occurs in the same cycle: ramp load with S=target and T=in_data directly (bypass); pend_v stays 0.
  - Else: state <= IDLE.
- busy = (state==RAMP), registered with the state.
- A new sample never aborts a ramp in progress; it is applied only after the current ramp completes.
- Reset mid-ramp: immediate return to the reset values; any pending sample is discarded.

Test Plan:
- log2_steps=2, step_en=1 constantly, from reset, accept 100 -> out_data 25, 50, 75, 100 on 4 consecutive cycles; out_strobe=1 on each of those 4 cycles; busy falls after the 4th.
- From 100, accept -100 -> out_data 50, 0, -50, -100. From 0, accept 3 -> 0, 1, 2, 3. From 0, accept -3 -> -1, -2, -3, -3 (floor rounding).
- data_bits=16, log2_steps=8: ramp from 32767 to -32768 -> monotonic non-increasing out_data with no wrap; final value -32768 after exactly 256 steps.
- log2_steps=2: accept 40 and then 80 during the ramp -> in_ready=0 after the second accept; a third in_valid is not accepted; output is 10, 20, 30, 40, 50, 60, 70, 80 with no gap cycle; in_ready returns to 1 after the reload.
- step_en pulsed every 3rd cycle, accept 100 with log2_steps=2 -> out_data changes only on step_en cycles; 4 strobes total; out_data and acc hold between ticks.
- rst driven to 0 mid-ramp with pend_v=1 -> out_data=0, busy=0, in_ready=0 immediately; after release, in_ready=1 and the pending sample is never output.
